// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: feeder FSM states, padding constants, hash-core IV/K tables,
// and the padded-word selection rule used while assembling each 16-word block.
package sha256_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      OFFER  = 2'd2,
      FINISH = 2'd3
   } feeder_state_e;

   localparam logic [31:0] PAD_WORD = 32'h80000000;

   localparam logic [31:0] SHA256_IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] SHA256_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // g is the global word index across all blocks; nb is the total block count.
   // The upper length word (index nb*16-2) falls through to zero because the bit length fits in 32 bits.
   function automatic logic [31:0] pad_word(input logic [7:0]  g,
                                            input logic [7:0]  msg_words,
                                            input logic [4:0]  nb,
                                            input logic [31:0] mem_word);
      logic [8:0] total;
      total = {nb, 4'd0};
      if (g < msg_words)
         return mem_word;
      else if (g == msg_words)
         return PAD_WORD;
      else if ({1'b0, g} == total - 9'd1)
         return {19'd0, msg_words, 5'd0};
      else
         return 32'd0;
   endfunction

endpackage

// File: rtl/sha256_block_feeder.sv
// Reads a word message from memory, applies SHA-256 padding and offers it as a sequence of
// 16-word blocks. Handshake: a block transfers on any cycle where block_valid && block_ready.
module sha256_block_feeder
   import sha256_pkg::*;
#(
   parameter int MAX_WORDS = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       base_addr,
   input  logic [7:0]        msg_words,
   output logic [15:0]       mem_addr,
   input  logic [31:0]       mem_read_data,
   output logic [15:0][31:0] block,
   output logic              block_valid,
   input  logic              block_ready,
   output logic              block_first,
   output logic              block_last,
   output logic [7:0]        block_idx,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

   feeder_state_e     state_q, state_d;
   logic [4:0]        t_q, t_d;
   logic [7:0]        idx_q, idx_d;
   logic [15:0]       base_q, base_d;
   logic [7:0]        len_q, len_d;
   logic [4:0]        nb_q, nb_d;
   logic              err_q, err_d;
   logic [15:0][31:0] blk_q, blk_d;
   logic [15:0]       mem_addr_q, mem_addr_d;

   logic [4:0]        t_m1;
   logic [7:0]        g_cur, g_prev;
   logic [8:0]        nb_calc;
   logic              is_last;

   assign is_last = (idx_q == {3'd0, nb_q - 5'd1});

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      idx_d      = idx_q;
      base_d     = base_q;
      len_d      = len_q;
      nb_d       = nb_q;
      err_d      = err_q;
      blk_d      = blk_q;
      mem_addr_d = mem_addr_q;
      t_m1       = t_q - 5'd1;
      g_cur      = {idx_q[3:0], t_q[3:0]};
      g_prev     = {idx_q[3:0], t_m1[3:0]};
      nb_calc    = ({1'b0, msg_words} + 9'd18) >> 4;

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d = base_addr;
               len_d  = msg_words;
               nb_d   = nb_calc[4:0];
               idx_d  = 8'd0;
               t_d    = 5'd0;
               if (msg_words > MAX_W8) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else begin
                  err_d   = 1'b0;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            // Address issued at step t returns at step t+1, so capture lags the read by one.
            if (!t_q[4] && (g_cur < len_q))
               mem_addr_d = base_q + {8'd0, g_cur};
            if (t_q != 5'd0)
               blk_d[t_m1[3:0]] = pad_word(g_prev, len_q, nb_q, mem_read_data);
            if (t_q == 5'd16)
               state_d = OFFER;
            else
               t_d = t_q + 5'd1;
         end
         OFFER: begin
            if (block_ready) begin
               if (is_last) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  t_d     = 5'd0;
                  state_d = FETCH;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         t_q        <= 5'd0;
         idx_q      <= 8'd0;
         base_q     <= 16'd0;
         len_q      <= 8'd0;
         nb_q       <= 5'd0;
         err_q      <= 1'b0;
         blk_q      <= '0;
         mem_addr_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         len_q      <= len_d;
         nb_q       <= nb_d;
         err_q      <= err_d;
         blk_q      <= blk_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign mem_addr    = mem_addr_d;
   assign block       = blk_q;
   assign block_idx   = idx_q;
   assign block_valid = (state_q == OFFER);
   assign block_first = block_valid && (idx_q == 8'd0);
   assign block_last  = block_valid && is_last;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FINISH);
   assign error       = done && err_q;

endmodule
